// File: rtl/ami_types_pkg.sv
// rtl/ami_types_pkg.sv - shared AMI request types and arbiter defaults
package AMITypes;

    typedef struct packed {
        logic [63:0] addr;
        logic        is_write;
        logic [5:0]  size;
    } AMIRequest;

    localparam int DNN_ARB_MAX_BURST_DEFAULT = 16;

endpackage

// File: rtl/dnn_rr_pick.sv
// rtl/dnn_rr_pick.sv - combinational round-robin pick with owner hold
module dnn_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   owner,
    input  logic               hold,
    output logic [IDX_W-1:0]   sel,
    output logic               found
);

    int idx;

    // Scan ends on the owner itself, so a lone owner still wins past its burst limit.
    always_comb begin
        sel   = owner;
        found = 1'b0;
        idx   = 0;
        if (hold) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = (int'(owner) + i) % NUM_REQ;
                if (!found && req_valid[IDX_W'(idx)]) begin
                    sel   = IDX_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dnn_ami_req_arbiter.sv
// rtl/dnn_ami_req_arbiter.sv - round-robin AMI request arbiter; stats built with DNN_ARB_STATS_EN
module dnn_ami_req_arbiter
    import AMITypes::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = DNN_ARB_MAX_BURST_DEFAULT,
    parameter int BURST_W   = $clog2(MAX_BURST + 1),
    parameter int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  AMIRequest [NUM_REQ-1:0]     req_in,
    output logic [NUM_REQ-1:0]          req_grant,
    output logic                        ami_req_valid,
    output AMIRequest                   ami_req,
    input  logic                        ami_req_grant,
    output logic [NUM_REQ-1:0][31:0]    stat_grants,
    output logic [31:0]                 stat_stall_cycles
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    logic [IDX_W-1:0]   owner;
    logic [BURST_W-1:0] burst_cnt;
    logic               out_valid;
    AMIRequest          out_req;

    logic               can_accept;
    logic               hold;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               grant_any;

    assign can_accept = !out_valid || ami_req_grant;

    // burst_cnt is zero only after reset: no burst in progress, so the scan from owner+1 picks requester 0.
    assign hold = req_valid[owner] && (burst_cnt != '0) && (burst_cnt < BURST_MAX);

    dnn_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .owner     (owner),
        .hold      (hold),
        .sel       (sel),
        .found     (found)
    );

    assign grant_any = !rst && can_accept && found;

    always_comb begin
        req_grant = '0;
        if (grant_any) begin
            req_grant[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_req   <= '0;
        end else if (grant_any) begin
            out_req   <= req_in[sel];
            out_valid <= 1'b1;
            if (sel == owner) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                owner     <= sel;
                burst_cnt <= BURST_W'(1);
            end
        end else if (ami_req_grant && out_valid) begin
            out_valid <= 1'b0;
        end
    end

    assign ami_req_valid = out_valid;
    assign ami_req       = out_req;

`ifdef DNN_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (grant_any) begin
                stat_grants[sel] <= stat_grants[sel] + 32'd1;
            end
            if (out_valid && !ami_req_grant) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`else
    assign stat_grants       = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dnn_ami_req_arbiter.sv
// tb/tb_dnn_ami_req_arbiter.sv - randomized model-checked bench for dnn_ami_req_arbiter
module tb_dnn_ami_req_arbiter;
    import AMITypes::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]         rv   [3];
    AMIRequest [1:0]    ri   [3];
    logic               ag   [3];
    logic [1:0]         gnt  [3];
    logic               aov  [3];
    AMIRequest          areq [3];
    logic [1:0][31:0]   sg   [3];
    logic [31:0]        ss   [3];

    dnn_ami_req_arbiter #(.NUM_REQ(2), .MAX_BURST(16)) u_b16 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_in(ri[0]), .req_grant(gnt[0]),
        .ami_req_valid(aov[0]), .ami_req(areq[0]), .ami_req_grant(ag[0]),
        .stat_grants(sg[0]), .stat_stall_cycles(ss[0]));

    dnn_ami_req_arbiter #(.NUM_REQ(2), .MAX_BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_in(ri[1]), .req_grant(gnt[1]),
        .ami_req_valid(aov[1]), .ami_req(areq[1]), .ami_req_grant(ag[1]),
        .stat_grants(sg[1]), .stat_stall_cycles(ss[1]));

    dnn_ami_req_arbiter #(.NUM_REQ(2), .MAX_BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_in(ri[2]), .req_grant(gnt[2]),
        .ami_req_valid(aov[2]), .ami_req(areq[2]), .ami_req_grant(ag[2]),
        .stat_grants(sg[2]), .stat_stall_cycles(ss[2]));

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          mb [3] = '{16, 4, 1};
    bit          stats_on;

    // Reference: last winner, length of its current run, output slot, counters.
    int          m_owner [3];
    int          m_run   [3];
    bit          m_ov    [3];
    AMIRequest   m_oreq  [3];
    int unsigned m_sg    [3][2];
    int unsigned m_ss    [3];
    logic [1:0]  last_g  [3];

    function automatic AMIRequest rnd_req();
        AMIRequest r;
        r.addr     = {$urandom, $urandom};
        r.is_write = 1'($urandom);
        r.size     = 6'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = 1;
            m_run[k]   = 0;
            m_ov[k]    = 1'b0;
            m_oreq[k]  = '0;
            m_sg[k][0] = 0;
            m_sg[k][1] = 0;
            m_ss[k]    = 0;
        end
    endtask

    task automatic set_idle();
        for (int k = 0; k < 3; k++) begin
            rv[k]    = 2'b00;
            ag[k]    = 1'b1;
            ri[k][0] = rnd_req();
            ri[k][1] = rnd_req();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Inputs are set by the caller just after a falling edge; this checks and advances one cycle.
    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) begin
            int          sel;
            bit          found;
            bit          can;
            logic [1:0]  eg;
            int unsigned exp_sg0, exp_sg1, exp_ss;
            sel   = 0;
            found = 1'b0;
            if (rv[k][m_owner[k]] && m_run[k] > 0 && m_run[k] < mb[k]) begin
                sel   = m_owner[k];
                found = 1'b1;
            end else begin
                for (int j = 1; j <= 2; j++) begin
                    if (!found && rv[k][(m_owner[k] + j) % 2]) begin
                        sel   = (m_owner[k] + j) % 2;
                        found = 1'b1;
                    end
                end
            end
            can = !m_ov[k] || ag[k];
            eg  = 2'b00;
            if (can && found) eg[sel] = 1'b1;
            exp_sg0 = stats_on ? m_sg[k][0] : 0;
            exp_sg1 = stats_on ? m_sg[k][1] : 0;
            exp_ss  = stats_on ? m_ss[k] : 0;

            total++;
            if (gnt[k] !== eg) begin
                bad++;
                $display("FAIL grant k=%0d cyc=%0d got=%b want=%b", k, cyc, gnt[k], eg);
            end
            total++;
            if (aov[k] !== m_ov[k]) begin
                bad++;
                $display("FAIL out_valid k=%0d cyc=%0d got=%b want=%b", k, cyc, aov[k], m_ov[k]);
            end
            total++;
            if (areq[k] !== m_oreq[k]) begin
                bad++;
                $display("FAIL out_req k=%0d cyc=%0d got=%h want=%h", k, cyc, areq[k], m_oreq[k]);
            end
            total++;
            if (sg[k][0] !== exp_sg0 || sg[k][1] !== exp_sg1 || ss[k] !== exp_ss) begin
                bad++;
                $display("FAIL stats k=%0d cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         k, cyc, sg[k][0], sg[k][1], ss[k], exp_sg0, exp_sg1, exp_ss);
            end
            last_g[k] = gnt[k];

            if (m_ov[k] && !ag[k]) m_ss[k]++;
            if (can && found) begin
                m_oreq[k] = ri[k][sel];
                m_ov[k]   = 1'b1;
                m_sg[k][sel]++;
                if (sel == m_owner[k]) begin
                    m_run[k]++;
                end else begin
                    m_owner[k] = sel;
                    m_run[k]   = 1;
                end
            end else if (ag[k] && m_ov[k]) begin
                m_ov[k] = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        for (int k = 0; k < 3; k++) rv[k] = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (gnt[k] !== 2'b00 || aov[k] !== 1'b0 || areq[k] !== '0 ||
                ss[k] !== 32'd0 || sg[k] !== '0) begin
                bad++;
                $display("FAIL reset_state k=%0d got gnt=%b v=%b req=%h ss=%0d", k, gnt[k], aov[k], areq[k], ss[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_idle();
    endtask

    task automatic test_single_path();
        logic [63:0] base;
        base = 64'h0000_1000_0000_0040;
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            rv[0]         = 2'b01;
            ri[0][0]      = rnd_req();
            ri[0][0].addr = base + 64'(8 * n);
            step();
            total++;
            if (last_g[0] !== 2'b01 || aov[0] !== 1'b1 || areq[0].addr !== base + 64'(8 * n)) begin
                bad++;
                $display("FAIL single_path n=%0d got g=%b v=%b addr=%h want addr=%h",
                         n, last_g[0], aov[0], areq[0].addr, base + 64'(8 * n));
            end
        end
        rv[0] = 2'b00;
        step();
        step();
    endtask

    task automatic test_burst();
        logic [1:0] w4, w1;
        apply_reset();
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 3; k++) begin
                rv[k]    = 2'b11;
                ag[k]    = 1'b1;
                ri[k][0] = rnd_req();
                ri[k][1] = rnd_req();
            end
            step();
            w4 = ((n / 4) % 2 == 0) ? 2'b01 : 2'b10;
            w1 = (n % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if (last_g[1] !== w4) begin
                bad++;
                $display("FAIL burst4 n=%0d got=%b want=%b", n, last_g[1], w4);
            end
            total++;
            if (last_g[2] !== w1) begin
                bad++;
                $display("FAIL burst1 n=%0d got=%b want=%b", n, last_g[2], w1);
            end
        end
    endtask

    task automatic test_backpressure();
        AMIRequest held;
        apply_reset();
        for (int k = 0; k < 3; k++) rv[k] = 2'b01;
        step();
        held = ri[0][0];
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 3; k++) begin
                rv[k]    = 2'b11;
                ag[k]    = 1'b0;
                ri[k][0] = rnd_req();
                ri[k][1] = rnd_req();
            end
            step();
            total++;
            if (last_g[0] !== 2'b00 || areq[0] !== held) begin
                bad++;
                $display("FAIL stall n=%0d got g=%b req=%h want g=00 req=%h", n, last_g[0], areq[0], held);
            end
        end
        for (int k = 0; k < 3; k++) ag[k] = 1'b1;
        step();
        total++;
        if (ss[0] !== (stats_on ? 32'd3 : 32'd0)) begin
            bad++;
            $display("FAIL stall_count got=%0d want=%0d", ss[0], stats_on ? 3 : 0);
        end
    endtask

    task automatic test_write_alone();
        int runs;
        runs = 0;
        apply_reset();
        for (int n = 0; n < 36; n++) begin
            for (int k = 0; k < 3; k++) begin
                rv[k]    = 2'b10;
                ri[k][1] = rnd_req();
            end
            step();
            if (last_g[0] === 2'b10) runs++;
        end
        total++;
        if (runs != 36) begin
            bad++;
            $display("FAIL write_alone got=%0d want=36", runs);
        end
        for (int k = 0; k < 3; k++) rv[k] = 2'b11;
        step();
        total++;
        if (last_g[0] !== 2'b01) begin
            bad++;
            $display("FAIL read_after_write got=%b want=01", last_g[0]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            rv[k] = 2'b01;
            ag[k] = 1'b0;
        end
        step();
        total++;
        if (aov[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid got=%b want=1", aov[0]);
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (aov[k] !== 1'b0 || areq[k] !== '0) begin
                bad++;
                $display("FAIL async_reset k=%0d got v=%b req=%h want v=0 req=0", k, aov[k], areq[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            rv[k] = 2'b11;
            ag[k] = 1'b1;
        end
        step();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (last_g[k] !== 2'b01) begin
                bad++;
                $display("FAIL first_after_reset k=%0d got=%b want=01", k, last_g[k]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 3; k++) begin
                rv[k]    = 2'($urandom_range(0, 3));
                ag[k]    = ($urandom % 4) != 0;
                ri[k][0] = rnd_req();
                ri[k][1] = rnd_req();
            end
            step();
        end
    endtask

    initial begin
`ifdef DNN_ARB_STATS_EN
        stats_on = 1'b1;
`else
        stats_on = 1'b0;
`endif
        rst = 1'b1;
        set_idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_path();
        test_burst();
        test_backpressure();
        test_write_alone();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dnn_ami_req_arbiter.md
# dnn_ami_req_arbiter

Shares the single AMI request port of a DNNWeaver memory slice between its request paths: the read-request path (requester 0) and the write-request path (requester 1). Selection is round-robin with bounded burst stickiness. The winning `AMIRequest` is registered into a one-entry output stage that drives the memory system. Each path sees a grant/valid handshake identical to its `reqValid`/`reqOut_grant` contract; the arbiter presents that same contract upstream to the AMI port.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters; index 0 = read path, 1 = write path.
- `MAX_BURST`, 16, maximum consecutive grants to one owner while another requester is waiting; legal range ≥ 1.
- `BURST_W`, `$clog2(MAX_BURST+1)`, width of the burst counter.
- `IDX_W`, `$clog2(NUM_REQ)` (minimum 1), width of the owner index.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, `NUM_REQ`: requester i holds a valid request.
- `req_in`, in, `NUM_REQ` × `AMIRequest`: request payload per requester.
- `req_grant`, out, `NUM_REQ`: combinational, one-hot or zero; requester i dequeues on `req_grant[i] && req_valid[i]`.
- `ami_req_valid`, out, 1: output stage holds a request.
- `ami_req`, out, `AMIRequest`: output stage payload.
- `ami_req_grant`, in, 1: memory system accepts `ami_req` this cycle.
- `stat_grants`, out, `NUM_REQ` × 32: grants per requester (see Configuration).
- `stat_stall_cycles`, out, 32: cycles with `ami_req_valid && !ami_req_grant`.

## Operation
- `can_accept` = `!ami_req_valid || ami_req_grant`.
- State: `owner` (`IDX_W`), `burst_cnt` (`BURST_W`), output register (`out_valid`, `out_req`).
- Selection:
  - The owner keeps priority while `req_valid[owner]` is high and `burst_cnt < MAX_BURST`.
  - Otherwise, the first valid requester scanning `owner+1, owner+2, …` (mod `NUM_REQ`) wins.
  - If only the owner is valid, the owner wins even when `burst_cnt == MAX_BURST`; in that case the counter saturates at `MAX_BURST` and does not wrap.
- Grant: `req_grant[sel] = can_accept && req_valid[sel]`. All other grant bits are 0.
- On grant:
  - `out_req <= req_in[sel]` and `out_valid <= 1`.
  - If `sel == owner`, increment `burst_cnt` (saturating). Otherwise set `owner <= sel` and `burst_cnt <= 1`.
- Drain without a new grant: `ami_req_grant && ami_req_valid` with no grant → `out_valid <= 0`.
- Grant and drain in the same cycle: the register is replaced with the new request. There is no bubble.
- `ami_req_grant` while `!ami_req_valid` has no effect.
- `req_in` is ignored for any requester whose `req_valid` is low.
- No reordering within a requester. No ordering guarantee across requesters; RAW ordering is owned by the layer above.

## Timing
- Reset values: `ami_req_valid=0`, `ami_req='0`, `req_grant=0`, `owner=NUM_REQ-1` (so requester 0 wins first), `burst_cnt=0`, stats 0.
- Latency: a grant in cycle N gives `ami_req_valid=1` in cycle N+1.
- Throughput: one request per cycle with `ami_req_grant` held high.
- Backpressure: while the output register is full and `ami_req_grant=0`, all grants are 0.
- Reset mid-operation: the output register is discarded immediately (async). Requesters must not treat any grant during reset as accepted.
- Stats counters wrap at 2^32.

## Configuration
- `DNN_ARB_STATS_EN`:
  - Defined: `stat_grants[i]` increments on each grant to requester i, and `stat_stall_cycles` increments on each stall cycle.
  - Undefined: no counter logic is built; the stat ports stay on the port list, tied to 0.

## Structure
- Shared package (`AMITypes`): `AMIRequest` (existing) and a new `DNN_ARB_MAX_BURST_DEFAULT` constant.
- One sub-module: `dnn_rr_pick`. It is combinational and takes `req_valid`, `owner`, and a hold flag, and returns `sel` and a found flag.
- The top level holds the owner, burst, output and stats registers.

## Test plan
- Requester 0 only, `ami_req_grant=1`, 5 requests → 5 grants in consecutive cycles; `ami_req` in cycles 1..5 matches addresses A..A+32.
- Both requesters continuously valid, `MAX_BURST=4` → grant sequence 0,0,0,0,1,1,1,1,0…
- `MAX_BURST=1`, both valid → grants alternate 0,1,0,1.
- `ami_req_grant` low for 3 cycles with the register full → `req_grant=0` for those 3 cycles; `ami_req` held stable; `stat_stall_cycles=3` with `DNN_ARB_STATS_EN`.
- Write path alone for 20 cycles with `MAX_BURST=16` → 20 consecutive grants; `burst_cnt` saturates at 16 without wrap. The read path then asserts → it is granted on the next available slot.
- Assert `rst` while `ami_req_valid=1` → `ami_req_valid=0` in the same cycle. After release, the first grant goes to requester 0.
